zuc_keystream_ctrl: RTL and testbench

Sequencer for the ZUC stream-cipher core: holds the 16×31-bit LFSR and the R1/R2 FSM registers, performs bit reorganization, and drives an external combinational F-function unit. It runs the 32-round initialization, the discard round, and then keystream generation. Keystream words are delivered one 32-bit word per cycle under a valid/ready handshake. It sits between the key/IV loader and the encrypt/MAC datapaths.

---
 rtl/zuc_pkg.sv | 32 +++
 rtl/zuc_lfsr_fb.sv | 27 ++
 rtl/zuc_keystream_ctrl.sv | 134 +++++++++++++
 tb/tb_zuc_keystream_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/zuc_pkg.sv
// Shared constants, FSM encoding and mod (2^31-1) arithmetic helpers for the ZUC sequencer.
package zuc_pkg;

  localparam logic [30:0] P           = 31'h7FFFFFFF;
  localparam int unsigned INIT_ROUNDS = 32;

  localparam logic [14:0] ZUC_D [16] = '{
    15'h44D7, 15'h26BC, 15'h626B, 15'h135E, 15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
    15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1, 15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC
  };

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DISCARD,
    GEN,
    DRAIN
  } zuc_state_e;

  // Multiplication by 2^k modulo 2^31-1.
  function automatic logic [30:0] rotl31(input logic [30:0] x, input int unsigned k);
    return (x << k) | (x >> (31 - k));
  endfunction

  // Addition modulo 2^31-1 with end-around carry; operands must not exceed P.
  function automatic logic [30:0] addm(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] c;
    c = {1'b0, a} + {1'b0, b};
    return c[30:0] + {30'b0, c[31]};
  endfunction

endpackage

// File: rtl/zuc_lfsr_fb.sv
// Combinational LFSR feedback s16 for ZUC, in initialization or work mode.
module zuc_lfsr_fb
  import zuc_pkg::*;
(
  input  logic [30:0] s0,
  input  logic [30:0] s4,
  input  logic [30:0] s10,
  input  logic [30:0] s13,
  input  logic [30:0] s15,
  input  logic [30:0] u,
  input  logic        mode,
  output logic [30:0] s16
);

  logic [30:0] t0, t1, t2, t3, v, sum;

  always_comb begin
    t0  = addm(s0, rotl31(s0, 8));
    t1  = addm(t0, rotl31(s4, 20));
    t2  = addm(t1, rotl31(s10, 21));
    t3  = addm(t2, rotl31(s13, 17));
    v   = addm(t3, rotl31(s15, 15));
    sum = mode ? addm(v, u) : v;
    s16 = (sum == '0) ? P : sum;
  end

endmodule

// File: rtl/zuc_keystream_ctrl.sv
// ZUC sequencer: LFSR and R1/R2 state, bit reorganization, init/discard/generate
// control and a one-word valid/ready output register around an external F unit.
module zuc_keystream_ctrl
  import zuc_pkg::*;
#(
  parameter int unsigned KS_LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [127:0]        key,
  input  logic [127:0]        iv,
  input  logic [KS_LEN_W-1:0] ks_len,
  output logic [31:0]         f_x0,
  output logic [31:0]         f_x1,
  output logic [31:0]         f_x2,
  output logic [31:0]         f_r1,
  output logic [31:0]         f_r2,
  input  logic [31:0]         f_w,
  input  logic [31:0]         f_r1_nxt,
  input  logic [31:0]         f_r2_nxt,
  output logic [31:0]         ks_data,
  output logic                ks_valid,
  input  logic                ks_ready,
  output logic                busy,
  output logic                done
);

  zuc_state_e          state;
  logic [30:0]         s [16];
  logic [31:0]         r1, r2;
  logic [4:0]          rnd;
  logic [KS_LEN_W-1:0] remaining;

  logic [31:0] x3;
  logic [30:0] s16;
  logic        adv;
  logic        step;

  // Operands come straight from registers, so the external F unit closes no loop.
  assign f_x0 = {s[15][30:15], s[14][15:0]};
  assign f_x1 = {s[11][15:0], s[9][30:15]};
  assign f_x2 = {s[7][15:0],  s[5][30:15]};
  assign x3   = {s[2][15:0],  s[0][30:15]};
  assign f_r1 = r1;
  assign f_r2 = r2;

  always_comb begin
    adv  = !ks_valid || ks_ready;
    step = (state == INIT) || (state == DISCARD) || ((state == GEN) && adv);
  end

  zuc_lfsr_fb u_fb (
    .s0   (s[0]),
    .s4   (s[4]),
    .s10  (s[10]),
    .s13  (s[13]),
    .s15  (s[15]),
    .u    (f_w[31:1]),
    .mode (state == INIT),
    .s16  (s16)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int unsigned i = 0; i < 16; i++) s[i] <= '0;
      r1        <= '0;
      r2        <= '0;
      rnd       <= '0;
      remaining <= '0;
      ks_data   <= '0;
      ks_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // R1/R2 update and LFSR shift are shared by INIT, DISCARD and advancing GEN.
      if (step) begin
        r1 <= f_r1_nxt;
        r2 <= f_r2_nxt;
        for (int unsigned i = 0; i < 15; i++) s[i] <= s[i+1];
        s[15] <= s16;
      end

      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < 16; i++)
              s[i] <= {key[127-8*i -: 8], ZUC_D[i], iv[127-8*i -: 8]};
            r1        <= '0;
            r2        <= '0;
            remaining <= ks_len;
            rnd       <= '0;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          rnd <= rnd + 5'd1;
          if (rnd == 5'(INIT_ROUNDS - 1)) state <= DISCARD;
        end
        DISCARD: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DRAIN;
          end else begin
            state <= GEN;
          end
        end
        GEN: begin
          if (adv) begin
            ks_data   <= f_w ^ x3;
            ks_valid  <= 1'b1;
            remaining <= remaining - KS_LEN_W'(1);
            if (remaining == KS_LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (adv) begin
            ks_valid <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zuc_keystream_ctrl.sv
// Directed bench for zuc_keystream_ctrl with a behavioural ZUC F unit (S0/S1, L1/L2).
module tb_zuc_keystream_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] iv;
  logic [15:0]  ks_len;
  logic [31:0]  f_x0, f_x1, f_x2, f_r1, f_r2;
  logic [31:0]  f_w, f_r1_nxt, f_r2_nxt;
  logic [31:0]  ks_data;
  logic         ks_valid;
  logic         ks_ready;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  zuc_keystream_ctrl #(.KS_LEN_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .iv       (iv),
    .ks_len   (ks_len),
    .f_x0     (f_x0),
    .f_x1     (f_x1),
    .f_x2     (f_x2),
    .f_r1     (f_r1),
    .f_r2     (f_r2),
    .f_w      (f_w),
    .f_r1_nxt (f_r1_nxt),
    .f_r2_nxt (f_r2_nxt),
    .ks_data  (ks_data),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  localparam logic [0:255][7:0] S0 = {
    128'h3e725b47cae0003304d1549809b96dcb, 128'h7b1bf932af9d6aa5b82dfc1d08530390,
    128'h4d4e8499e4ced991ddb685488b296eac, 128'hcdc1f81e734369c6b5bdfd396320d438,
    128'h767db2a7cfed57c5f32cbb142106559b, 128'he3ef5e314f7f5aa40d8251495fba581c,
    128'h4a16d517a892241f8cffd8ae2e01d3ad, 128'h3b4bda46ebc9de9a8f87d73a806f2fc8,
    128'hb1b437f70a2213287ccc3c89c7c39656, 128'h07bf7ef00b2b975235417961a64c10fe,
    128'hbc2695888ab0a3fbc01894f2e1e5e95d, 128'hd0dc1166645cec59427512f5749caa23,
    128'h0e86abbe2a02e767e644a26cc2939ff1, 128'hf6fa36d250689e6271153dd640c4e20f,
    128'h8e83776b25053f0c30ea70b7a1e8a965, 128'h8d271adb81b3a0f4457a19dfee783460
  };

  localparam logic [0:255][7:0] S1 = {
    128'h55c263713bc847869f3cda5b29aafd77, 128'h8cc5940ca61a1300e3a8167240f9f842,
    128'h4426689681d9453e1076c6a78b3943e1, 128'h3ab5562ac06db3052266bfdc0bfa6248,
    128'hdd20110636c9c1cff62752bb69f5d487, 128'h7f844cd29c57a4bc4f9adffed68d7aeb,
    128'h2b53d85ca11417fb23d57d3067730809, 128'heeb7703f61b2198e4ee54b938f5ddba9,
    128'hadf1ae2ecb0dfcf42d466e1d97e8d1e9, 128'h4d37a5755e839eab829db91ce0cd4989,
    128'h01b6bd5824a25f387899159050b895e4, 128'hd091c7ceed0fb46fa0ccf0024a79c3de,
    128'ha3efea51e66b18ec1b2c80f774e7ff21, 128'h5a6a541e41319235c433070aba7e0e34,
    128'h88b1987cf33d606c7bcad31f32650428, 128'h64be859b2f598ad7b025acaf1203e2f2
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] l1(input logic [31:0] x);
    return x ^ rotl(x, 2) ^ rotl(x, 10) ^ rotl(x, 18) ^ rotl(x, 24);
  endfunction

  function automatic logic [31:0] l2(input logic [31:0] x);
    return x ^ rotl(x, 8) ^ rotl(x, 14) ^ rotl(x, 22) ^ rotl(x, 30);
  endfunction

  function automatic logic [31:0] sbox(input logic [31:0] x);
    return {S0[x[31:24]], S1[x[23:16]], S0[x[15:8]], S1[x[7:0]]};
  endfunction

  logic [31:0] w1, w2;
  always_comb begin
    f_w      = (f_x0 ^ f_r1) + f_r2;
    w1       = f_r1 + f_x1;
    w2       = f_r2 ^ f_x2;
    f_r1_nxt = sbox(l1({w1[15:0], w2[31:16]}));
    f_r2_nxt = sbox(l2({w2[15:0], w1[31:16]}));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one session from the start edge (edge 0) to the cycle after done.
  task automatic session(input logic [127:0] k, input logic [127:0] v, input logic [15:0] n,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input bit rnd_ready, input bit poke_start, input string tag);
    logic [31:0] ew [2];
    int          got;
    int          first_v;
    int          done_c;
    bit          stalled;
    bit          rdy;
    logic [31:0] held;
    ew[0] = e0; ew[1] = e1;
    got = 0; first_v = -1; done_c = 0; stalled = 0; held = '0;
    @(negedge clk);
    key = k; iv = v; ks_len = n; start = 1'b1; ks_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy_start"}, 32'(busy), 32'd1);
      if (done_c > 0) begin
        check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_valid_after_done"}, 32'(ks_valid), 32'd0);
        break;
      end
      if (stalled) begin
        check({tag, "_stall_data"}, ks_data, held);
        check({tag, "_stall_valid"}, 32'(ks_valid), 32'd1);
      end
      if (ks_valid && first_v < 0) first_v = c;
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ks_ready = rdy;
      start = poke_start && (c == 35);
      if (ks_valid && rdy) begin
        if (got < int'(n)) check($sformatf("%s_word%0d", tag, got), ks_data, ew[got]);
        else check({tag, "_extra_word"}, 32'(got + 1), 32'(n));
        got++;
      end
      stalled = ks_valid && !rdy;
      held = ks_data;
      if (done) begin
        done_c = c;
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
      end
    end
    ks_ready = 1'b1;
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done_c > 0), 32'd1);
    if (!rnd_ready) check({tag, "_done_cycle"}, 32'(done_c), (n == 0) ? 32'd34 : 32'(35 + n));
    check({tag, "_first_valid"}, 32'(first_v), (n == 0) ? 32'hFFFF_FFFF : 32'd35);
    check({tag, "_word_count"}, 32'(got), 32'(n));
  endtask

  localparam logic [127:0] K3 = 128'h3D4C4BE96A82FDAEB58F641DB17B455B;
  localparam logic [127:0] I3 = 128'h84319AA8DE6915CA1F6BDA6BFBD8C766;

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b1; start = 1'b0; key = '0; iv = '0; ks_len = '0; ks_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ks_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", ks_data, 32'd0);
    check("rst_fx0", f_x0, 32'd0);
    check("rst_fr1", f_r1, 32'd0);
    rst = 1'b0;

    session('0, '0, 16'd2, 32'h27BEDE74, 32'h018082DA, 1'b0, 1'b0, "v1");
    session('1, '1, 16'd2, 32'h0657CFA0, 32'h7096398B, 1'b0, 1'b0, "v2");
    session(K3, I3, 16'd2, 32'h14F1C272, 32'h3279C419, 1'b0, 1'b0, "v3");
    session(K3, I3, 16'd2, 32'h14F1C272, 32'h3279C419, 1'b1, 1'b0, "v3_bp");
    session('0, '0, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0, "len0");

    // Abort in INIT cycle 20, then restart.
    @(negedge clk);
    key = '0; iv = '0; ks_len = 16'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", 32'(ks_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", ks_data, 32'd0);
    check("abort_fx0", f_x0, 32'd0);
    check("abort_fx1", f_x1, 32'd0);
    check("abort_fx2", f_x2, 32'd0);
    check("abort_fr1", f_r1, 32'd0);
    check("abort_fr2", f_r2, 32'd0);
    session('0, '0, 16'd2, 32'h27BEDE74, 32'h018082DA, 1'b0, 1'b0, "v1_restart");

    session('0, '0, 16'd2, 32'h27BEDE74, 32'h018082DA, 1'b0, 1'b1, "v1_poke");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
